// File: rtl/mp_addsub_pipe.sv
// Pipelined multi-precision add/sub: stage 1 precomputes both carry-in sums
// per limb, stage 2 resolves the limb carry chain and selects the result.
// Ports: clk, reset (sync, active-high), in_valid, leftshift, subtract,
//   in_a/in_b [WIDTH-1:0] in; out_valid, result [WIDTH:0], borrow out.
// Build option: define MPADD_RESULT_REG_EN to register the outputs
//   (latency 2); otherwise outputs come combinationally from stage 1.
module mp_addsub_pipe #(
  parameter int WIDTH = 1027,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             leftshift,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH:0]   result,
  output logic             borrow
);

  localparam int L  = (WIDTH + LIMB - 1) / LIMB;
  // Top limb carries the remainder bits plus the sign-extension bit.
  localparam int TW = WIDTH - (L - 1) * LIMB;
  localparam int TE = TW + 1;

  typedef logic [LIMB:0] limb_t;

  function automatic limb_t limb_add(
    input logic [LIMB-1:0] a,
    input logic [LIMB-1:0] b,
    input logic            c
  );
    return {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, c};
  endfunction

  function automatic limb_t top_add(
    input logic [TE-1:0] a,
    input logic [TE-1:0] b,
    input logic          c
  );
    limb_t r;
    r = '0;
    r[TE-1:0] = a + b + TE'(c);
    return r;
  endfunction

  logic [WIDTH-1:0] b_sh;
  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   b_x;

  always_comb begin
    b_sh = leftshift ? {in_b[WIDTH-2:0], 1'b0} : in_b;
    a_x  = {1'b0, in_a};
    // Inverting the extended b' makes the extension bit 1 for subtract.
    b_x  = subtract ? ~{1'b0, b_sh} : {1'b0, b_sh};
  end

  limb_t s0_d [L];
  limb_t s1_d [L];
  limb_t s0_q [L];
  limb_t s1_q [L];
  logic  sub_d, sub_q;
  logic  v_d, v_q;

  always_comb begin
    for (int i = 0; i < L; i++) begin
      s0_d[i] = s0_q[i];
      s1_d[i] = s1_q[i];
    end
    sub_d = sub_q;
    v_d   = in_valid;
    if (in_valid) begin
      sub_d   = subtract;
      // Limb 0 knows its real carry-in, so only one sum is kept.
      s0_d[0] = limb_add(a_x[LIMB-1:0], b_x[LIMB-1:0], subtract);
      s1_d[0] = '0;
      for (int i = 1; i < L - 1; i++) begin
        s0_d[i] = limb_add(a_x[i*LIMB +: LIMB],
                           b_x[i*LIMB +: LIMB], 1'b0);
        s1_d[i] = limb_add(a_x[i*LIMB +: LIMB],
                           b_x[i*LIMB +: LIMB], 1'b1);
      end
      s0_d[L-1] = top_add(a_x[(L-1)*LIMB +: TE],
                          b_x[(L-1)*LIMB +: TE], 1'b0);
      s1_d[L-1] = top_add(a_x[(L-1)*LIMB +: TE],
                          b_x[(L-1)*LIMB +: TE], 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) begin
        s0_q[i] <= '0;
        s1_q[i] <= '0;
      end
      sub_q <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      for (int i = 0; i < L; i++) begin
        s0_q[i] <= s0_d[i];
        s1_q[i] <= s1_d[i];
      end
      sub_q <= sub_d;
      v_q   <= v_d;
    end
  end

  logic [WIDTH:0] res_c;
  logic           borrow_c;

  always_comb begin
    logic c;
    res_c = '0;
    c     = s0_q[0][LIMB];
    res_c[LIMB-1:0] = s0_q[0][LIMB-1:0];
    for (int i = 1; i < L - 1; i++) begin
      res_c[i*LIMB +: LIMB] = c ? s1_q[i][LIMB-1:0]
                                : s0_q[i][LIMB-1:0];
      c = c ? s1_q[i][LIMB] : s0_q[i][LIMB];
    end
    res_c[(L-1)*LIMB +: TE] = c ? s1_q[L-1][TE-1:0]
                                : s0_q[L-1][TE-1:0];
    borrow_c = sub_q & res_c[WIDTH];
  end

`ifdef MPADD_RESULT_REG_EN
  logic [WIDTH:0] res_d, res_q;
  logic           bor_d, bor_q;
  logic           ov_d, ov_q;

  always_comb begin
    res_d = res_q;
    bor_d = bor_q;
    ov_d  = v_q;
    if (v_q) begin
      res_d = res_c;
      bor_d = borrow_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      bor_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      bor_q <= bor_d;
      ov_q  <= ov_d;
    end
  end

  assign result    = res_q;
  assign borrow    = bor_q;
  assign out_valid = ov_q;
`else
  assign result    = res_c;
  assign borrow    = borrow_c;
  assign out_valid = v_q;
`endif

endmodule

// File: tb/tb_mp_addsub_pipe.sv
// Scoreboard bench for mp_addsub_pipe at 1027/64 and 130/32 against
// an arithmetic reference model.
module tb_mp_addsub_pipe;

  localparam int W1 = 1027;
  localparam int W2 = 130;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          iv1, ls1, sb1, ov1, bw1;
  logic [W1-1:0] a1, b1;
  logic [W1:0]   r1;
  logic          iv2, ls2, sb2, ov2, bw2;
  logic [W2-1:0] a2, b2;
  logic [W2:0]   r2;

  mp_addsub_pipe #(.WIDTH(W1), .LIMB(64)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1),
    .leftshift(ls1), .subtract(sb1),
    .in_a(a1), .in_b(b1),
    .out_valid(ov1), .result(r1), .borrow(bw1)
  );

  mp_addsub_pipe #(.WIDTH(W2), .LIMB(32)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2),
    .leftshift(ls2), .subtract(sb2),
    .in_a(a2), .in_b(b2),
    .out_valid(ov2), .result(r2), .borrow(bw2)
  );

  int errs = 0;
  int checks = 0;

  logic [W1+1:0] q1 [$];
  logic [W2+1:0] q2 [$];
  logic [W1+1:0] e1;
  logic [W2+1:0] e2;

  function automatic logic [W1+1:0] model1(
    input logic [W1-1:0] a, input logic [W1-1:0] b,
    input logic ls, input logic sb);
    logic [W1-1:0] bs;
    logic [W1:0]   r;
    bs = ls ? (b << 1) : b;
    if (sb) r = {1'b0, a} - {1'b0, bs};
    else    r = {1'b0, a} + {1'b0, bs};
    return {sb && (a < bs), r};
  endfunction

  function automatic logic [W2+1:0] model2(
    input logic [W2-1:0] a, input logic [W2-1:0] b,
    input logic ls, input logic sb);
    logic [W2-1:0] bs;
    logic [W2:0]   r;
    bs = ls ? (b << 1) : b;
    if (sb) r = {1'b0, a} - {1'b0, bs};
    else    r = {1'b0, a} + {1'b0, bs};
    return {sb && (a < bs), r};
  endfunction

  // Words biased to 0 / all-ones to provoke long carry chains.
  function automatic logic [W1-1:0] rnd1();
    logic [W1+31:0] v;
    for (int i = 0; i < (W1 + 31) / 32; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*32 +: 32] = 32'h0;
        1:       v[i*32 +: 32] = 32'hffff_ffff;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    return v[W1-1:0];
  endfunction

  function automatic logic [W2-1:0] rnd2();
    logic [W2+31:0] v;
    for (int i = 0; i < (W2 + 31) / 32; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*32 +: 32] = 32'h0;
        1:       v[i*32 +: 32] = 32'hffff_ffff;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    return v[W2-1:0];
  endfunction

  always @(negedge clk) begin
    if (ov1) begin
      checks++;
      if (q1.size() == 0) begin
        errs++;
        $display("FAIL dut1 spurious out_valid: got 1 want 0");
      end else begin
        e1 = q1.pop_front();
        if ({bw1, r1} !== e1) begin
          errs++;
          $display("FAIL dut1 result: got bw=%b hi=%h lo=%h want bw=%b hi=%h lo=%h",
                   bw1, r1[W1:W1-63], r1[63:0],
                   e1[W1+1], e1[W1:W1-63], e1[63:0]);
        end
      end
    end
    if (ov2) begin
      checks++;
      if (q2.size() == 0) begin
        errs++;
        $display("FAIL dut2 spurious out_valid: got 1 want 0");
      end else begin
        e2 = q2.pop_front();
        if ({bw2, r2} !== e2) begin
          errs++;
          $display("FAIL dut2 result: got bw=%b r=%h want bw=%b r=%h",
                   bw2, r2, e2[W2+1], e2[W2:0]);
        end
      end
    end
  end

  task automatic op1(input logic [W1-1:0] a, input logic [W1-1:0] b,
                     input logic ls, input logic sb,
                     input logic [W1+1:0] e, input bit push);
    iv1 = 1'b1; a1 = a; b1 = b; ls1 = ls; sb1 = sb;
    if (push) q1.push_back(e);
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  task automatic rop1(input bit push);
    logic [W1-1:0] a, b;
    logic ls, sb;
    a = rnd1(); b = rnd1();
    ls = 1'($urandom_range(0, 1));
    sb = 1'($urandom_range(0, 1));
    op1(a, b, ls, sb, model1(a, b, ls, sb), push);
  endtask

  task automatic chk(input string name, input logic [W1+2:0] got,
                     input logic [W1+2:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, got[63:0], want[63:0]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W1-1:0] a, b;
    logic [W1+1:0] e;
    logic [W2-1:0] x, y;
    logic lsx, sbx;
    reset = 1'b1;
    iv1 = 0; ls1 = 0; sb1 = 0; a1 = '0; b1 = '0;
    iv2 = 0; ls2 = 0; sb2 = 0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset ov1", (W1+3)'(ov1), '0);
    chk("reset r1", (W1+3)'({bw1, r1}), '0);
    chk("reset r2", (W1+3)'({ov2, bw2, r2}), '0);

    // Full carry ripple across all limbs.
    a = '1; b = '0; b[0] = 1'b1;
    e = '0; e[W1] = 1'b1;
    op1(a, b, 1'b0, 1'b0, e, 1'b1);
    // 5 - 7 wraps to all ones except bit 0, borrow set.
    a = W1'(5); b = W1'(7);
    e = '1; e[0] = 1'b0;
    op1(a, b, 1'b0, 1'b1, e, 1'b1);
    a = W1'(7); b = W1'(5);
    e = (W1+2)'(2);
    op1(a, b, 1'b0, 1'b1, e, 1'b1);
    // Leftshift drops the MSB of b.
    a = '0; b = '0; b[W1-1] = 1'b1; b[1:0] = 2'b11;
    e = (W1+2)'(6);
    op1(a, b, 1'b1, 1'b0, e, 1'b1);
    idle(3);

    // Eight back-to-back random operations.
    for (int i = 0; i < 8; i++) rop1(1'b1);
    idle(3);

    // Reset the cycle after an accepted op: the op only reaches the
    // outputs if the build has no output register.
`ifdef MPADD_RESULT_REG_EN
    rop1(1'b0);
`else
    rop1(1'b1);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post-reset ov1", (W1+3)'(ov1), '0);
    chk("post-reset r1", (W1+3)'({bw1, r1}), '0);
    // in_valid together with reset is ignored.
    reset = 1'b1;
    rop1(1'b0);
    reset = 1'b0;
    idle(4);
    chk("ignored op r1", (W1+3)'({ov1, bw1, r1}), '0);
    for (int i = 0; i < 3; i++) rop1(1'b1);
    idle(3);

    // Narrow instance: 1000 random ops with random gaps.
    for (int i = 0; i < 1000; i++) begin
      x = rnd2(); y = rnd2();
      lsx = 1'($urandom_range(0, 1));
      sbx = 1'($urandom_range(0, 1));
      iv2 = 1'b1; a2 = x; b2 = y; ls2 = lsx; sb2 = sbx;
      q2.push_back(model2(x, y, lsx, sbx));
      @(posedge clk); #1;
      iv2 = 1'b0;
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    for (int i = 0; i < 10; i++) begin
      if (q1.size() != 0 || q2.size() != 0) idle(1);
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               q1.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
